riscv_multicycle_control: RTL

Multicycle control unit for the RISC-V core. A Moore FSM sequences fetch, decode, execute, memory and writeback over several clocks, sharing one ALU and one memory port. It adds a memory ready/request handshake with arbitrary wait states, full RV32I branch conditions, LUI, optional MUL, and a sticky illegal-instruction trap. It sits between the instruction register/ALU flags and the datapath mux selects and write strobes.

---
 rtl/riscv_ctrl_pkg.sv | 80 ++++++++
 rtl/riscv_alu_decoder.sv | 59 +++++
 rtl/riscv_multicycle_control.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle control unit: opcodes, state encoding,
// ALU operation codes and datapath mux select codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_BRANCH, S_JAL, S_JALR_ADR,
        S_JALR_PC, S_ALUWB, S_TRAP
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_MUL   = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Base RV32I funct3 mapping shared by register and immediate ALU ops.
    function automatic logic [3:0] base_alu_op(input logic [2:0] funct3);
        case (funct3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero, input logic lt,
                                          input logic ltu);
        case (funct3)
            3'd0:    return zero;
            3'd1:    return !zero;
            3'd4:    return lt;
            3'd5:    return !lt;
            3'd6:    return ltu;
            3'd7:    return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational funct/opcode decode to an ALU operation, flagging encodings
// this core configuration does not implement.
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter bit SUPPORT_MUL = 1'b1,
    parameter bit FULL_BRANCH = 1'b1
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct7)
                    7'h00: alu_op = base_alu_op(funct3);
                    7'h20: begin
                        if (funct3 == 3'd0)      alu_op = ALU_SUB;
                        else if (funct3 == 3'd5) alu_op = ALU_SRA;
                        else                     illegal = 1'b1;
                    end
                    7'h01: begin
                        if (SUPPORT_MUL && funct3 == 3'd0) alu_op = ALU_MUL;
                        else                               illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_I: begin
                // Only the shift immediates carry meaning in funct7.
                case (funct3)
                    3'd1: begin
                        alu_op  = ALU_SLL;
                        illegal = (funct7 != 7'h00);
                    end
                    3'd5: begin
                        if (funct7 == 7'h00)      alu_op = ALU_SRL;
                        else if (funct7 == 7'h20) alu_op = ALU_SRA;
                        else                      illegal = 1'b1;
                    end
                    default: alu_op = base_alu_op(funct3);
                endcase
            end
            OP_BRANCH: begin
                alu_op = ALU_SUB;
                if (funct3[2:1] == 2'b01)          illegal = 1'b1;
                else if (funct3[2] && !FULL_BRANCH) illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared ALU and one memory port with a ready handshake.
module riscv_multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter bit SUPPORT_MUL = 1'b1,
    parameter bit FULL_BRANCH = 1'b1,
    parameter int ALUOP_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               zero,
    input  logic               lt,
    input  logic               ltu,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         imm_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal
);

    state_t     state, next_state;
    logic [3:0] dec_op, op;
    logic       dec_illegal;

    riscv_alu_decoder #(
        .SUPPORT_MUL(SUPPORT_MUL),
        .FULL_BRANCH(FULL_BRANCH)
    ) u_alu_decoder (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .alu_op (dec_op),
        .illegal(dec_illegal)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_RST:    next_state = S_FETCH;
            S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:      next_state = S_EXEC_R;
                    OP_I:      next_state = S_EXEC_I;
                    OP_LUI:    next_state = S_EXEC_LUI;
                    OP_BRANCH: next_state = dec_illegal ? S_TRAP : S_BRANCH;
                    OP_JAL:    next_state = S_JAL;
                    OP_JALR:   next_state = S_JALR_ADR;
                    OP_AUIPC:  next_state = S_ALUWB;
                    default:   next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXEC_R, S_EXEC_I: next_state = dec_illegal ? S_TRAP : S_ALUWB;
            S_EXEC_LUI: next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_JALR_ADR: next_state = S_JALR_PC;
            S_JALR_PC:  next_state = S_ALUWB;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_RST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_RST;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_TRAP) illegal <= 1'b1;
        end
    end

    // Outputs decode from the state register; only the fetch strobes and the
    // branch pc_write also look at same-cycle inputs (mem_ready, ALU flags).
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = A_PC;
        alu_src_b  = B_RS2;
        imm_src    = IMM_I;
        op         = ALU_ADD;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = B_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = A_OLDPC;
                alu_src_b = B_IMM;
                if (opcode == OP_BRANCH)                          imm_src = IMM_B;
                else if (opcode == OP_JAL)                        imm_src = IMM_J;
                else if (opcode == OP_LUI || opcode == OP_AUIPC)  imm_src = IMM_U;
            end
            S_MEMADR: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                if (opcode == OP_STORE) imm_src = IMM_S;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = A_RS1;
                op        = dec_op;
            end
            S_EXEC_I: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                op        = dec_op;
            end
            S_EXEC_LUI: begin
                alu_src_b = B_IMM;
                imm_src   = IMM_U;
                op        = ALU_PASSB;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = A_RS1;
                op        = ALU_SUB;
                pc_write  = branch_taken(funct3, zero, lt, ltu);
            end
            S_JAL, S_JALR_PC: begin
                pc_write  = 1'b1;
                alu_src_a = A_OLDPC;
                alu_src_b = B_FOUR;
            end
            S_JALR_ADR: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
            end
            default: ;
        endcase
        alu_op = ALUOP_W'(op);
    end

endmodule
